add_reducer_scheduler: RTL and testbench

Shares a single pipelined 8-addend adder-tree reducer between the 8 hardware threads. Each thread deposits addends into its own slot buffer at any order and pace. When all slots are filled, the block round-robin issues that thread's vector into the reducer, tracks it through the pipeline with a thread tag, and holds the sum until the thread reads it. Sits between the thread write ports and the reducer datapath.

---
 rtl/add_reducer_scheduler_if.sv | 40 ++++
 rtl/add_reducer_scheduler.sv | 157 +++++++++++++++
 tb/tb_add_reducer_scheduler.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/add_reducer_scheduler_if.sv
// rtl/add_reducer_scheduler_if.sv - thread write/read and reducer-side signal bundle
// Purpose: groups the addend write port, result read port and reducer
//   datapath signals of add_reducer_scheduler.
// Ports (modport slave = scheduler view):
//   wr_valid/wr_ready/wr_thread/wr_slot/wr_data  addend write handshake
//   rd_en/rd_thread/rd_data/rd_valid              result read
//   result_pending                                per-thread DONE flags
//   red_addends/red_reduction                     reducer input vector / output sum
//   error                                         sticky protocol error
interface add_reducer_scheduler_if #(
  parameter int WORD_WIDTH   = 36,
  parameter int ADDENDS      = 8,
  parameter int THREADS      = 8,
  parameter int THREAD_WIDTH = 3,
  parameter int SLOT_WIDTH   = 3
);
  logic                          wr_valid;
  logic                          wr_ready;
  logic [THREAD_WIDTH-1:0]       wr_thread;
  logic [SLOT_WIDTH-1:0]         wr_slot;
  logic [WORD_WIDTH-1:0]         wr_data;
  logic                          rd_en;
  logic [THREAD_WIDTH-1:0]       rd_thread;
  logic [WORD_WIDTH-1:0]         rd_data;
  logic                          rd_valid;
  logic [THREADS-1:0]            result_pending;
  logic [ADDENDS*WORD_WIDTH-1:0] red_addends;
  logic [WORD_WIDTH-1:0]         red_reduction;
  logic                          error;

  modport slave (
    input  wr_valid, wr_thread, wr_slot, wr_data, rd_en, rd_thread, red_reduction,
    output wr_ready, rd_data, rd_valid, result_pending, red_addends, error
  );

  modport master (
    output wr_valid, wr_thread, wr_slot, wr_data, rd_en, rd_thread, red_reduction,
    input  wr_ready, rd_data, rd_valid, result_pending, red_addends, error
  );
endinterface

// File: rtl/add_reducer_scheduler.sv
// rtl/add_reducer_scheduler.sv - shares one pipelined 8-addend reducer among 8 threads
// Purpose: per-thread slot buffers fill in any order; a completed vector is
//   round-robin issued to the reducer, tracked by a thread tag pipeline, and
//   its sum held until the owning thread reads it.
// Ports:
//   clock   sole clock
//   reset   synchronous, active-high
//   bus     add_reducer_scheduler_if.slave (write, read, reducer signals)
// Optional feature: define ADD_REDUCER_SCHED_ERROR_EN to enable the sticky
//   protocol error flag; otherwise error is tied 0.
module add_reducer_scheduler #(
  parameter int WORD_WIDTH      = 36,
  parameter int ADDENDS         = 8,
  parameter int THREADS         = 8,
  parameter int THREAD_WIDTH    = 3,
  parameter int SLOT_WIDTH      = 3,
  parameter int REDUCER_LATENCY = 5
) (
  input logic                    clock,
  input logic                    reset,
  add_reducer_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_READY = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } thread_state_t;

  thread_state_t state_q [THREADS];
  thread_state_t state_d [THREADS];

  logic [ADDENDS-1:0]            mask_q [THREADS];
  logic [WORD_WIDTH-1:0]         buf_q  [THREADS][ADDENDS];
  logic [WORD_WIDTH-1:0]         result_q [THREADS];
  logic [THREAD_WIDTH-1:0]       last_issued_q;
  logic [REDUCER_LATENCY:0]      tag_valid_q;
  logic [THREAD_WIDTH-1:0]       tag_thread_q [REDUCER_LATENCY+1];
  logic [WORD_WIDTH-1:0]         rd_data_q;
  logic                          rd_valid_q;
  logic [ADDENDS*WORD_WIDTH-1:0] red_addends_q;

  logic                    wr_accept;
  logic [ADDENDS-1:0]      wr_mask_next;
  logic                    wr_completes;
  logic                    rd_accept;
  logic                    issue_valid;
  logic [THREAD_WIDTH-1:0] issue_thread;
  logic [THREAD_WIDTH-1:0] arb_cand;
  logic                    cap_valid;
  logic [THREAD_WIDTH-1:0] cap_thread;

  assign wr_accept    = bus.wr_valid && (state_q[bus.wr_thread] == ST_FILL);
  assign wr_mask_next = mask_q[bus.wr_thread] | (ADDENDS'(1) << bus.wr_slot);
  assign wr_completes = &wr_mask_next;
  assign rd_accept    = bus.rd_en && (state_q[bus.rd_thread] == ST_DONE);
  assign cap_valid    = tag_valid_q[REDUCER_LATENCY];
  assign cap_thread   = tag_thread_q[REDUCER_LATENCY];

  // Round-robin arbiter: the search starts one past the last issued thread.
  // THREADS is a power of two, so the THREAD_WIDTH-bit sum wraps as mod THREADS;
  // the final iteration lands back on last_issued itself.
  always_comb begin
    issue_valid  = 1'b0;
    issue_thread = '0;
    arb_cand     = '0;
    for (int i = 1; i <= THREADS; i++) begin
      arb_cand = last_issued_q + THREAD_WIDTH'(i);
      if (!issue_valid && state_q[arb_cand] == ST_READY) begin
        issue_valid  = 1'b1;
        issue_thread = arb_cand;
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int t = 0; t < THREADS; t++) state_q[t] <= ST_FILL;
    end else begin
      for (int t = 0; t < THREADS; t++) state_q[t] <= state_d[t];
    end
  end

  // Next-state logic. A thread sits in exactly one state, so the four events
  // below can never target the same thread in one cycle.
  always_comb begin
    for (int t = 0; t < THREADS; t++) state_d[t] = state_q[t];
    if (wr_accept && wr_completes) state_d[bus.wr_thread] = ST_READY;
    if (issue_valid)               state_d[issue_thread]  = ST_BUSY;
    if (cap_valid)                 state_d[cap_thread]    = ST_DONE;
    if (rd_accept)                 state_d[bus.rd_thread] = ST_FILL;
  end

  // Outputs decoded from thread state
  always_comb begin
    bus.wr_ready       = (state_q[bus.wr_thread] == ST_FILL);
    bus.result_pending = '0;
    for (int t = 0; t < THREADS; t++) bus.result_pending[t] = (state_q[t] == ST_DONE);
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.red_addends = red_addends_q;

  // Control state with reset. Clearing tag_valid_q on reset is what makes the
  // reducer output of any in-flight vector get ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int t = 0; t < THREADS; t++) mask_q[t] <= '0;
      tag_valid_q   <= '0;
      last_issued_q <= THREAD_WIDTH'(THREADS - 1);
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      red_addends_q <= '0;
    end else begin
      if (wr_accept) mask_q[bus.wr_thread] <= wr_mask_next;
      if (rd_accept) mask_q[bus.rd_thread] <= '0;
      tag_valid_q <= {tag_valid_q[REDUCER_LATENCY-1:0], issue_valid};
      if (issue_valid) begin
        last_issued_q <= issue_thread;
        for (int k = 0; k < ADDENDS; k++)
          red_addends_q[k*WORD_WIDTH +: WORD_WIDTH] <= buf_q[issue_thread][k];
      end
      rd_valid_q <= rd_accept;
      if (rd_accept) rd_data_q <= result_q[bus.rd_thread];
    end
  end

  // Data storage; only meaningful under the mask/tag/state qualifiers above.
  always_ff @(posedge clock) begin
    if (wr_accept) buf_q[bus.wr_thread][bus.wr_slot] <= bus.wr_data;
    tag_thread_q[0] <= issue_thread;
    for (int s = 1; s <= REDUCER_LATENCY; s++) tag_thread_q[s] <= tag_thread_q[s-1];
    if (cap_valid) result_q[cap_thread] <= bus.red_reduction;
  end

`ifdef ADD_REDUCER_SCHED_ERROR_EN
  logic error_q;
  logic error_event;

  assign error_event = (bus.wr_valid && (state_q[bus.wr_thread] != ST_FILL))
                    || (wr_accept && mask_q[bus.wr_thread][bus.wr_slot])
                    || (bus.rd_en && (state_q[bus.rd_thread] != ST_DONE));

  always_ff @(posedge clock) begin
    if (reset)            error_q <= 1'b0;
    else if (error_event) error_q <= 1'b1;
  end

  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_add_reducer_scheduler.sv
// tb/tb_add_reducer_scheduler.sv - randomized self-checking bench for add_reducer_scheduler
module tb_add_reducer_scheduler;
  localparam int WORD_WIDTH      = 36;
  localparam int ADDENDS         = 8;
  localparam int THREADS         = 8;
  localparam int THREAD_WIDTH    = 3;
  localparam int SLOT_WIDTH      = 3;
  localparam int REDUCER_LATENCY = 5;
  localparam int VEC_WIDTH       = ADDENDS * WORD_WIDTH;
`ifdef ADD_REDUCER_SCHED_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  add_reducer_scheduler_if #(
    .WORD_WIDTH(WORD_WIDTH), .ADDENDS(ADDENDS), .THREADS(THREADS),
    .THREAD_WIDTH(THREAD_WIDTH), .SLOT_WIDTH(SLOT_WIDTH)
  ) bus ();

  add_reducer_scheduler #(
    .WORD_WIDTH(WORD_WIDTH), .ADDENDS(ADDENDS), .THREADS(THREADS),
    .THREAD_WIDTH(THREAD_WIDTH), .SLOT_WIDTH(SLOT_WIDTH),
    .REDUCER_LATENCY(REDUCER_LATENCY)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // Reducer stand-in: sum of the presented vector, REDUCER_LATENCY edges later.
  logic [WORD_WIDTH-1:0] red_pipe [REDUCER_LATENCY];
  logic [WORD_WIDTH-1:0] red_sum_now;
  always_comb begin
    red_sum_now = '0;
    for (int k = 0; k < ADDENDS; k++) red_sum_now = red_sum_now + bus.red_addends[k*WORD_WIDTH +: WORD_WIDTH];
  end
  always @(posedge clock) begin
    red_pipe[0] <= red_sum_now;
    for (int s = 1; s < REDUCER_LATENCY; s++) red_pipe[s] <= red_pipe[s-1];
  end
  assign bus.red_reduction = red_pipe[REDUCER_LATENCY-1];

  // Reference: what each thread's slots hold, and the last value read out.
  logic [WORD_WIDTH-1:0] m_slot [THREADS][ADDENDS];
  logic [WORD_WIDTH-1:0] pend [ADDENDS];
  logic [WORD_WIDTH-1:0] last_rd;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [VEC_WIDTH-1:0] obs, input logic [VEC_WIDTH-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [WORD_WIDTH-1:0] model_sum(input int t);
    longint acc = 0;
    for (int k = 0; k < ADDENDS; k++) acc += longint'(m_slot[t][k]);
    return acc[WORD_WIDTH-1:0];
  endfunction

  function automatic logic [VEC_WIDTH-1:0] model_vec(input int t);
    logic [VEC_WIDTH-1:0] v;
    for (int k = 0; k < ADDENDS; k++) v[k*WORD_WIDTH +: WORD_WIDTH] = m_slot[t][k];
    return v;
  endfunction

  function automatic logic [WORD_WIDTH-1:0] rand_word();
    return {$urandom_range(15, 0), $urandom()};
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    bus.wr_valid = 1'b0;
    bus.rd_en    = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    last_rd = '0;
  endtask

  task automatic do_write(input int t, input int s, input logic [WORD_WIDTH-1:0] d, input bit exp_ready);
    bus.wr_valid  = 1'b1;
    bus.wr_thread = THREAD_WIDTH'(t);
    bus.wr_slot   = SLOT_WIDTH'(s);
    bus.wr_data   = d;
    @(negedge clock);
    check($sformatf("wr_ready t%0d s%0d", t, s), VEC_WIDTH'(bus.wr_ready), VEC_WIDTH'(exp_ready));
    @(posedge clock);
    #1 bus.wr_valid = 1'b0;
    if (exp_ready) m_slot[t][s] = d;
  endtask

  task automatic do_read(input int t, input bit exp_valid);
    bus.rd_en     = 1'b1;
    bus.rd_thread = THREAD_WIDTH'(t);
    @(posedge clock);
    #1 bus.rd_en = 1'b0;
    check($sformatf("rd_valid t%0d", t), VEC_WIDTH'(bus.rd_valid), VEC_WIDTH'(exp_valid));
    if (exp_valid) last_rd = model_sum(t);
    check($sformatf("rd_data t%0d", t), VEC_WIDTH'(bus.rd_data), VEC_WIDTH'(last_rd));
    @(posedge clock);
    #1 check($sformatf("rd_valid_drop t%0d", t), VEC_WIDTH'(bus.rd_valid), '0);
  endtask

  // Writes pend[] into every slot except skip, in a shuffled order.
  task automatic fill_thread(input int t, input int skip);
    int order [ADDENDS];
    int j, tmp;
    for (int k = 0; k < ADDENDS; k++) order[k] = k;
    for (int k = 0; k < ADDENDS - 1; k++) begin
      j = int'($urandom_range(ADDENDS - 1, k));
      tmp = order[k]; order[k] = order[j]; order[j] = tmp;
    end
    for (int k = 0; k < ADDENDS; k++)
      if (order[k] != skip) do_write(t, order[k], pend[order[k]], 1'b1);
  endtask

  // Called right after the completing write: issue next edge, capture
  // REDUCER_LATENCY+1 edges after that.
  task automatic track_issue(input int t);
    @(posedge clock);
    #1 check($sformatf("issue_vec t%0d", t), bus.red_addends, model_vec(t));
    repeat (REDUCER_LATENCY) @(posedge clock);
    #1 check($sformatf("pending_early t%0d", t), VEC_WIDTH'(bus.result_pending[t]), '0);
    @(posedge clock);
    #1 check($sformatf("pending_set t%0d", t), VEC_WIDTH'(bus.result_pending[t]), VEC_WIDTH'(1));
  endtask

  initial begin
    int perm [THREADS];
    int j, tmp, t;
    bus.wr_valid = 1'b0; bus.wr_thread = '0; bus.wr_slot = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_thread = '0;
    apply_reset();

    check("reset rd_valid", VEC_WIDTH'(bus.rd_valid), '0);
    check("reset rd_data", VEC_WIDTH'(bus.rd_data), '0);
    check("reset red_addends", bus.red_addends, '0);
    check("reset pending", VEC_WIDTH'(bus.result_pending), '0);
    check("reset error", VEC_WIDTH'(bus.error), '0);
    check("reset wr_ready", VEC_WIDTH'(bus.wr_ready), VEC_WIDTH'(1));

    // Thread 2, slots = 1..8 -> 36
    for (int k = 0; k < ADDENDS; k++) pend[k] = WORD_WIDTH'(k + 1);
    fill_thread(2, -1);
    track_issue(2);
    do_read(2, 1'b1);
    check("t2 sum 36", VEC_WIDTH'(bus.rd_data), VEC_WIDTH'(36));
    check("clean error", VEC_WIDTH'(bus.error), '0);

    // All threads complete on consecutive cycles -> issue 0..7 back to back
    for (int k = 0; k < ADDENDS - 1; k++)
      for (int i = 0; i < THREADS; i++) do_write(i, k, WORD_WIDTH'(i), 1'b1);
    for (int i = 0; i < THREADS; i++) begin
      do_write(i, ADDENDS - 1, WORD_WIDTH'(i), 1'b1);
      if (i > 0) check($sformatf("b2b issue t%0d", i - 1), bus.red_addends, model_vec(i - 1));
    end
    @(posedge clock);
    #1 check("b2b issue t7", bus.red_addends, model_vec(THREADS - 1));
    repeat (REDUCER_LATENCY + 1) @(posedge clock);
    #1 check("all pending", VEC_WIDTH'(bus.result_pending), VEC_WIDTH'({THREADS{1'b1}}));
    for (int i = 0; i < THREADS; i++) perm[i] = i;
    for (int i = 0; i < THREADS - 1; i++) begin
      j = int'($urandom_range(THREADS - 1, i));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    // First read collides with a write to the same DONE thread
    bus.wr_valid = 1'b1; bus.wr_thread = THREAD_WIDTH'(perm[0]); bus.wr_slot = '0; bus.wr_data = rand_word();
    bus.rd_en = 1'b1; bus.rd_thread = THREAD_WIDTH'(perm[0]);
    @(negedge clock);
    check("wr_ready on DONE", VEC_WIDTH'(bus.wr_ready), '0);
    @(posedge clock);
    #1 bus.wr_valid = 1'b0; bus.rd_en = 1'b0;
    check("collide rd_valid", VEC_WIDTH'(bus.rd_valid), VEC_WIDTH'(1));
    check("collide rd_data", VEC_WIDTH'(bus.rd_data), VEC_WIDTH'(WORD_WIDTH'(8 * perm[0])));
    last_rd = model_sum(perm[0]);
    check("collide error", VEC_WIDTH'(bus.error), VEC_WIDTH'(ERR_EN));
    for (int i = 1; i < THREADS; i++) begin
      do_read(perm[i], 1'b1);
      check($sformatf("sum 8*i t%0d", perm[i]), VEC_WIDTH'(bus.rd_data), VEC_WIDTH'(WORD_WIDTH'(8 * perm[i])));
    end
    check("none pending", VEC_WIDTH'(bus.result_pending), '0);
    apply_reset();

    // Thread 5 wrap-around
    for (int k = 0; k < ADDENDS; k++) pend[k] = 36'h7FFFFFFFF;
    fill_thread(5, -1);
    track_issue(5);
    do_read(5, 1'b1);
    check("t5 wrap", VEC_WIDTH'(bus.rd_data), VEC_WIDTH'(36'hFFFFFFFF8));

    // Write to thread 1 while BUSY is refused
    for (int k = 0; k < ADDENDS; k++) pend[k] = rand_word();
    fill_thread(1, -1);
    @(posedge clock);
    #1 check("t1 issue", bus.red_addends, model_vec(1));
    do_write(1, int'($urandom_range(ADDENDS - 1, 0)), rand_word(), 1'b0);
    check("busy write error", VEC_WIDTH'(bus.error), VEC_WIDTH'(ERR_EN));
    repeat (REDUCER_LATENCY + 1) @(posedge clock);
    #1 check("t1 pending", VEC_WIDTH'(bus.result_pending[1]), VEC_WIDTH'(1));
    do_read(1, 1'b1);
    apply_reset();

    // Reset while thread 3 is BUSY
    for (int k = 0; k < ADDENDS; k++) pend[k] = rand_word();
    fill_thread(3, -1);
    @(posedge clock);
    #1 check("t3 issue", bus.red_addends, model_vec(3));
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check("post-reset pending", VEC_WIDTH'(bus.result_pending), '0);
    repeat (REDUCER_LATENCY + 3) @(posedge clock);
    #1 check("no stale capture", VEC_WIDTH'(bus.result_pending), '0);
    check("no stale rd_valid", VEC_WIDTH'(bus.rd_valid), '0);
    last_rd = '0;
    for (int k = 0; k < ADDENDS; k++) pend[k] = rand_word();
    fill_thread(3, -1);
    track_issue(3);
    do_read(3, 1'b1);

    // Read of a FILL thread, then duplicate slot write on thread 6
    do_read(4, 1'b0);
    check("fill read error", VEC_WIDTH'(bus.error), VEC_WIDTH'(ERR_EN));
    apply_reset();
    for (int k = 0; k < ADDENDS; k++) pend[k] = rand_word();
    do_write(6, 6, WORD_WIDTH'(10), 1'b1);
    do_write(6, 6, WORD_WIDTH'(20), 1'b1);
    check("dup write error", VEC_WIDTH'(bus.error), VEC_WIDTH'(ERR_EN));
    fill_thread(6, 6);
    track_issue(6);
    do_read(6, 1'b1);
    check("dup uses 20", VEC_WIDTH'(bus.rd_data[WORD_WIDTH-1:0] - model_sum(6)), '0);
    check("dup slot6", VEC_WIDTH'(bus.red_addends[6*WORD_WIDTH +: WORD_WIDTH]), VEC_WIDTH'(20));
    apply_reset();

    // Random fills
    for (int r = 0; r < 8; r++) begin
      t = int'($urandom_range(THREADS - 1, 0));
      for (int k = 0; k < ADDENDS; k++) pend[k] = rand_word();
      fill_thread(t, -1);
      track_issue(t);
      do_read(t, 1'b1);
    end
    check("final error", VEC_WIDTH'(bus.error), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
